// File: rtl/mem_wb_pipe_reg.sv
// Valid/ready pipeline stage register with flush and a saturating back-pressure counter.
// Define MEM_WB_PIPE_SKID_EN for a two-entry skid buffer with registered in_ready.
module mem_wb_pipe_reg #(
    parameter int unsigned DATA_W = 136,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic              accept;
    logic              emit;

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign stall_cnt = stall_cnt_q;

    assign accept = in_valid && in_ready;
    assign emit   = main_valid_q && out_ready;

`ifdef MEM_WB_PIPE_SKID_EN
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;

    // in_ready depends only on a flop, so out_ready never reaches upstream combinationally.
    assign in_ready = !skid_valid_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (emit) begin
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end
`else
    assign in_ready = !main_valid_q || out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
        end else if (accept) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data;
        end else if (emit) begin
            main_valid_d = 1'b0;
        end
    end
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            stall_cnt_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Self-checking bench for mem_wb_pipe_reg: directed scenarios plus a queue-model random run.
module tb_mem_wb_pipe_reg;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 16;
`ifdef MEM_WB_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam int NPAY = 1000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] stall_cnt;

    logic          s_flush;
    logic          s_in_valid;
    logic          s_in_ready;
    logic [7:0]    s_in_data;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [7:0]    s_out_data;
    logic [2:0]    s_stall_cnt;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    mem_wb_pipe_reg #(.DATA_W(8), .CNT_W(3)) dut_sat (
        .clk(clk), .reset_n(reset_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .stall_cnt(s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        #2;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        vectors++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        vectors++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_pass_through();
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = DW'(i);
            tick();
            vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pass_valid[%0d] got %0b want 1", i, out_valid); end
            vectors++; if (out_data !== DW'(i)) begin errors++; $display("FAIL pass_data[%0d] got %h want %h", i, out_data, DW'(i)); end
        end
        vectors++; if (stall_cnt !== '0) begin errors++; $display("FAIL pass_stall got %0d want 0", stall_cnt); end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_back_pressure();
        logic exp_rdy;
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h000A;
        tick();
        out_ready = 1'b0; in_data = 16'h000B;
        for (int i = 0; i < 5; i++) begin
            #1;
            exp_rdy = SKID && (i == 0);
            vectors++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready[%0d] got %0b want %0b", i, in_ready, exp_rdy); end
            tick();
        end
        vectors++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL bp_stall got %0d want 5", stall_cnt); end
        vectors++; if (out_data !== 16'h000A) begin errors++; $display("FAIL bp_hold got %h want 000a", out_data); end
        out_ready = 1'b1;
        in_valid  = !SKID;
        tick();
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_second_valid got %0b want 1", out_valid); end
        vectors++; if (out_data !== 16'h000B) begin errors++; $display("FAIL bp_second_data got %h want 000b", out_data); end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_flush();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
        tick();
        in_data = 16'h0012;
        tick();
        flush = 1'b1; in_data = 16'h000C;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        vectors++; if (out_data !== 16'h0011) begin errors++; $display("FAIL flush_data_kept got %h want 0011", out_data); end
        vectors++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_stall got %0d want 2", stall_cnt); end
        vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
        // Accept on an empty stage during flush must be discarded.
        flush = 1'b1; in_valid = 1'b1; in_data = 16'h000E; out_ready = 1'b1;
        tick();
        flush = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_valid got %0b want 0", out_valid); end
        vectors++; if (out_data !== 16'h0011) begin errors++; $display("FAIL flush_accept_data got %h want 0011", out_data); end
        in_data = 16'h000D;
        tick();
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_next_valid got %0b want 1", out_valid); end
        vectors++; if (out_data !== 16'h000D) begin errors++; $display("FAIL flush_next_data got %h want 000d", out_data); end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0055;
        tick();
        in_valid = 1'b0;
        tick();
        vectors++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL areset_pre_stall got %0d want 1", stall_cnt); end
        #2;
        reset_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %0b want 0", out_valid); end
        vectors++; if (out_data !== '0) begin errors++; $display("FAIL areset_data got %h want 0", out_data); end
        vectors++; if (stall_cnt !== '0) begin errors++; $display("FAIL areset_stall got %0d want 0", stall_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
        in_valid = 1'b1; in_data = 16'h0066; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_first_valid got %0b want 1", out_valid); end
        vectors++; if (out_data !== 16'h0066) begin errors++; $display("FAIL areset_first_data got %h want 0066", out_data); end
        tick();
    endtask

    task automatic test_saturation();
        logic [2:0] exp;
        do_reset();
        s_in_valid = 1'b1; s_in_data = 8'h5A; s_out_ready = 1'b0;
        tick();
        s_in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            exp = (i < 7) ? 3'(i) : 3'd7;
            vectors++; if (s_stall_cnt !== exp) begin errors++; $display("FAIL sat_cnt[%0d] got %0d want %0d", i, s_stall_cnt, exp); end
        end
        vectors++; if (s_out_data !== 8'h5A) begin errors++; $display("FAIL sat_data got %h want 5a", s_out_data); end
    endtask

    task automatic test_random();
        logic [DW-1:0] src[NPAY];
        logic [DW-1:0] q[$];
        logic [CW-1:0] exp_cnt;
        logic          m_ready, m_valid, acc, emt;
        int            idx, recv, cyc;
        for (int i = 0; i < NPAY; i++) src[i] = DW'($urandom);
        do_reset();
        q.delete();
        exp_cnt = '0; idx = 0; recv = 0; cyc = 0;
        while (recv < NPAY && cyc < 20000) begin
            in_valid  = (idx < NPAY) && ($urandom_range(0, 9) < 7);
            in_data   = (idx < NPAY) ? src[idx] : DW'($urandom);
            out_ready = ($urandom_range(0, 9) < 6);
            #1;
            m_valid = (q.size() != 0);
            m_ready = SKID ? (q.size() < 2) : (!m_valid || out_ready);
            vectors++; if (in_ready !== m_ready) begin errors++; $display("FAIL rnd_in_ready@%0d got %0b want %0b", cyc, in_ready, m_ready); end
            vectors++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_out_valid@%0d got %0b want %0b", cyc, out_valid, m_valid); end
            vectors++; if (stall_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_stall@%0d got %0d want %0d", cyc, stall_cnt, exp_cnt); end
            if (m_valid) begin
                vectors++; if (out_data !== q[0]) begin errors++; $display("FAIL rnd_order@%0d got %h want %h", cyc, out_data, q[0]); end
            end
            acc = in_valid && m_ready;
            emt = m_valid && out_ready;
            if (m_valid && !out_ready && exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
            if (emt) begin void'(q.pop_front()); recv++; end
            if (acc) begin q.push_back(src[idx]); idx++; end
            tick();
            cyc++;
        end
        vectors++;
        if (recv != NPAY) begin errors++; $display("FAIL rnd_budget delivered %0d want %0d", recv, NPAY); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_back_pressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_pipe_reg.md
# mem_wb_pipe_reg

Parametrised pipeline stage register with a valid/ready handshake, flush, and a back-pressure stall counter. It is the next-generation replacement for the fixed-width MEM→WB boundary register and is reusable at any stage boundary of the core (IF/ID, ID/EX, EX/MEM, MEM/WB). Payload is an opaque bundle of `DATA_W` bits, for example `{reg_write, result_src, alu_result, read_data, rd, pc_plus, pc_target}` = 136 bits at MEM/WB. An optional skid buffer breaks the combinational ready path.

## Interface
- `DATA_W`, default 136: payload width in bits (≥1).
- `CNT_W`, default 16: stall counter width (≥1).

- `clk`  in  1: clock. All state updates on the rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: synchronous kill of all held entries.
- `in_valid`  in  1: upstream presents a payload.
- `in_ready`  out  1: stage accepts the payload this cycle.
- `in_data`  in  DATA_W: upstream payload.
- `out_valid`  out  1: stage presents a payload.
- `out_ready`  in  1: downstream accepts the payload this cycle.
- `out_data`  out  DATA_W: payload to downstream. Always driven from a register.
- `stall_cnt`  out  CNT_W: saturating count of back-pressured cycles.

## Operation
- Transfers:
  - Accept occurs when `in_valid && in_ready`.
  - Emit occurs when `out_valid && out_ready`.
  - Payload order is strictly FIFO. No payload is duplicated or dropped, except by `flush`.
- `out_data` changes only when a new entry loads into the output register. It holds its value while `out_valid=0`; downstream must qualify with `out_valid`.
- Without skid buffer (single entry):
  - `in_ready = !out_valid || out_ready`. This is a combinational path from `out_ready`.
  - Accept and emit in the same cycle gives a full-throughput pass-through.
- With skid buffer (two entries: main + skid):
  - `in_ready = !skid_valid`. This is registered, with no combinational path from `out_ready`.
  - An accept while main is full and not emitting loads the skid register.
  - On emit, main loads from skid if the skid is valid. Otherwise main loads from the input if an accept occurs. Otherwise main goes empty.
  - Skid and input never load main in the same cycle.
- Flush:
  - Highest priority.
  - In a flush cycle, an accept, if it occurs, is discarded.
  - Next cycle: `out_valid=0` and skid empty.
  - `out_data` is not cleared.
  - `in_ready` is not forced by `flush`.
- Stall counter:
  - Increments each cycle `out_valid && !out_ready`, including a flush cycle.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.

## Timing
- Reset state (asynchronous on `reset_n` low, held until release):
  - `out_valid=0`, `out_data=0`, skid empty, `stall_cnt=0`.
  - `in_ready`: 1 in both configurations.
- Reset asserted mid-transfer: all held entries are lost immediately. No partial state survives.
- The first accept is allowed on the first rising edge after `reset_n` deasserts.
- Latency: accept at edge N means `out_valid=1` with that payload after edge N. This is one cycle in both configurations when the stage is empty.
- Throughput: one payload per cycle while `out_ready=1`.
- Boundaries:
  - Full is main valid (no skid) or main and skid valid (skid).
  - Empty means `out_valid=0`.
  - Simultaneous accept + emit on a full single-entry stage is legal and keeps it full.
  - At counter saturation, the value holds with no wrap.

## Configuration
- `MEM_WB_PIPE_SKID_EN` defined:
  - Two-entry skid buffer with registered `in_ready`.
  - One extra `DATA_W`-bit register plus a valid bit.
- Not defined:
  - Single-entry register with combinational `in_ready`.
  - Interface and latency are identical in both cases.

## Test plan
- Pass-through:
  - Stimulus: `out_ready=1`, `in_valid=1` with payloads 0x1,0x2,0x3 on consecutive cycles.
  - Required: `out_data` shows 0x1,0x2,0x3 one cycle later with `out_valid=1` each cycle; `stall_cnt=0`.
- Back-pressure:
  - Stimulus: load 0xA, then hold `out_ready=0` for 5 cycles while `in_valid=1` with payload 0xB.
  - Required, no skid: `in_ready=0`, 0xA held, `stall_cnt=5`.
  - Required, skid: 0xB accepted into the skid, then `in_ready=0`.
  - On release, the output order is 0xA then 0xB.
- Flush:
  - Stimulus: with a full stage (skid full when enabled), assert `flush` for one cycle together with `in_valid=1` and payload 0xC.
  - Required: next cycle `out_valid=0`; 0xC never appears at the output; the next accepted payload 0xD emerges normally.
- Async reset mid-operation:
  - Stimulus: pull `reset_n` low between edges while the stage is full.
  - Required: `out_valid`, `out_data` and `stall_cnt` go to 0 without a clock edge; the first post-release accept emerges after 1 cycle.
- Saturation:
  - Stimulus: `CNT_W=3`, `out_valid=1`, `out_ready=0` for 10 cycles.
  - Required: `stall_cnt` stops at 7 and holds at 7.
- Randomised valid/ready:
  - Stimulus: 1000 random payloads with random `in_valid`/`out_ready` in both configurations.
  - Required: a scoreboard confirms in-order, lossless delivery.
